// File: rtl/div_counter.sv
// Programmable divided-clock / end-of-period tick generator with glitch-free divisor reload.
// Optional macro DIV_IMMEDIATE_LOAD_EN: reload the divisor on any change, restarting the period.
module div_counter #(
  parameter int WIDTH   = 32,
  parameter int MIN_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             En,
  input  logic [WIDTH-1:0] Div_In,
  output logic             Clk_Out,
  output logic             Tick,
  output logic             Pending,
  output logic [WIDTH-1:0] Count
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [WIDTH-1:0] MIN_VAL = WIDTH'(MIN_DIV);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] count_reg, count_next;
  logic [WIDTH-1:0] div_cur_reg, div_cur_next;
  logic             clk_out_reg, clk_out_next;
  logic             tick_reg, tick_next;
  logic             pending_reg, pending_next;
  logic [WIDTH-1:0] div_req;
  logic             run_next;

  assign div_req = (Div_In < MIN_VAL) ? MIN_VAL : Div_In;

  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    div_cur_next = div_cur_reg;
    case (state_reg)
      IDLE: begin
        if (En) begin
          state_next   = RUN;
          count_next   = '0;
          div_cur_next = div_req;
        end
      end
      RUN: begin
        if (!En) begin
          state_next = IDLE;
          count_next = '0;
`ifdef DIV_IMMEDIATE_LOAD_EN
        end else if (div_req != div_cur_reg) begin
          count_next   = '0;
          div_cur_next = div_req;
`endif
        end else if (count_reg == div_cur_reg - ONE) begin
          count_next   = '0;
          div_cur_next = div_req;
        end else begin
          count_next = count_reg + ONE;
        end
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

  // Outputs are computed from next-state values so they line up with Count.
  always_comb begin
    run_next     = (state_next == RUN);
    clk_out_next = run_next && (count_next < (div_cur_next >> 1));
    tick_next    = run_next && (count_next == div_cur_next - ONE);
`ifdef DIV_IMMEDIATE_LOAD_EN
    pending_next = 1'b0;
`else
    pending_next = run_next && (div_req != div_cur_next);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      div_cur_reg <= MIN_VAL;
      clk_out_reg <= 1'b0;
      tick_reg    <= 1'b0;
      pending_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      div_cur_reg <= div_cur_next;
      clk_out_reg <= clk_out_next;
      tick_reg    <= tick_next;
      pending_reg <= pending_next;
    end
  end

  assign Clk_Out = clk_out_reg;
  assign Tick    = tick_reg;
  assign Pending = pending_reg;
  assign Count   = count_reg;

endmodule

// File: tb/tb_div_counter.sv
// Self-checking bench for div_counter: directed scenarios followed by random En/rst/Div_In traffic.
module tb_div_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic        En;
  logic [31:0] Div_In;
  logic        Clk_Out;
  logic        Tick;
  logic        Pending;
  logic [31:0] Count;

  int total = 0;
  int bad   = 0;

  // Reference: a period is described by its start cycle and length.
  longint      cyc = 0;
  longint      pstart = 0;
  bit          mrun = 0;
  logic [31:0] mn = 32'd2;
  bit          mpend = 0;

  div_counter #(.WIDTH(32), .MIN_DIV(2)) dut (
    .clk(clk), .rst(rst), .En(En), .Div_In(Div_In),
    .Clk_Out(Clk_Out), .Tick(Tick), .Pending(Pending), .Count(Count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] clamp(input logic [31:0] x);
    return (x < 32'd2) ? 32'd2 : x;
  endfunction

  function automatic logic [31:0] pos();
    return mrun ? 32'(cyc - pstart) : 32'd0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit e, input logic [31:0] d);
    logic [31:0] c;
    logic [31:0] k;
    rst = r; En = e; Div_In = d;
    @(posedge clk);
    cyc++;
    c = clamp(d);
    if (r) begin
      mrun = 0; mn = 32'd2; mpend = 0;
    end else begin
      if (!mrun) begin
        if (e) begin mrun = 1; pstart = cyc; mn = c; end
      end else if (!e) begin
        mrun = 0;
`ifdef DIV_IMMEDIATE_LOAD_EN
      end else if (c != mn) begin
        pstart = cyc; mn = c;
`endif
      end else if (cyc - pstart >= longint'(mn)) begin
        pstart = cyc; mn = c;
      end
`ifdef DIV_IMMEDIATE_LOAD_EN
      mpend = 0;
`else
      mpend = mrun && (c != mn);
`endif
    end
    #1;
    k = pos();
    check("count",   Count,           k);
    check("clk_out", {31'd0, Clk_Out}, {31'd0, mrun && (k < (mn >> 1))});
    check("tick",    {31'd0, Tick},    {31'd0, mrun && (k == mn - 32'd1)});
    check("pending", {31'd0, Pending}, {31'd0, mpend});
    $display("cyc=%0d rst=%0b en=%0b div=%0d -> count=%0d clk_out=%0b tick=%0b pending=%0b",
             cyc, r, e, d, Count, Clk_Out, Tick, Pending);
  endtask

  task automatic run_until_pos(input logic [31:0] target, input logic [31:0] d);
    int n = 0;
    while (pos() != target && n < 40) begin
      step(0, 1, d);
      n++;
    end
    total++;
    assert (pos() == target) else begin
      bad++;
      $error("FAIL wait_pos observed=%0d expected=%0d", pos(), target);
    end
  endtask

  initial begin
    // reset and idle
    repeat (2) step(1, 0, 32'd4);
    repeat (10) step(0, 0, 32'd4);
    // basic, odd, clamp
    repeat (12) step(0, 1, 32'd4);
    repeat (2) step(0, 0, 32'd5);
    repeat (10) step(0, 1, 32'd5);
    repeat (2) step(0, 0, 32'd0);
    repeat (6) step(0, 1, 32'd0);
    repeat (6) step(0, 1, 32'd1);
    // boundary switch 6 -> 3 at count 1
    repeat (2) step(0, 0, 32'd6);
    step(0, 1, 32'd6);
    run_until_pos(32'd1, 32'd6);
    repeat (12) step(0, 1, 32'd3);
    // En drop at count 5, reassert, then rst at count 3
    repeat (2) step(0, 0, 32'd8);
    step(0, 1, 32'd8);
    run_until_pos(32'd5, 32'd8);
    repeat (2) step(0, 0, 32'd8);
    repeat (10) step(0, 1, 32'd8);
    run_until_pos(32'd3, 32'd8);
    step(1, 1, 32'd8);
    repeat (4) step(0, 1, 32'd8);
    // immediate-load scenario (boundary load in the default build)
    run_until_pos(32'd5, 32'd8);
    repeat (12) step(0, 1, 32'd4);
    // high divisor bits must be significant
    repeat (6) step(0, 1, 32'h0001_0000);
    repeat (2) step(0, 0, 32'd3);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] d = Div_In;
      if ($urandom_range(0, 7) == 0) d = $urandom_range(0, 9);
      step($urandom_range(0, 49) == 0, $urandom_range(0, 19) != 0, d);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
